// File: rtl/stack_pkg.sv
// Shared types and defaults for the RPN sequencer driving the 4-bit LIFO stack.
package stack_pkg;

  localparam int STACK_DATA_W = 4;
  localparam int STACK_DEPTH  = 5;
  localparam int STACK_IDX_W  = 3;

  typedef enum logic [1:0] {NOP, PUSH, POP, GET} stack_cmd_e;

  typedef enum logic [2:0] {
    OP_PUSHI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_DUP, OP_DROP
  } rpn_op_e;

  typedef enum logic [2:0] {
    RPN_IDLE, RPN_POP1, RPN_POP2, RPN_EXEC, RPN_GET, RPN_PUSH
  } rpn_state_e;

  // True when the token cannot run against the current stack occupancy.
  function automatic logic accept_error(rpn_op_e op, int count, int depth);
    case (op)
      OP_PUSHI: return count == depth;
      OP_DUP:   return (count == 0) || (count == depth);
      OP_DROP:  return count == 0;
      default:  return count < 2;
    endcase
  endfunction

endpackage

// File: rtl/stack_rpn_fn.sv
// Combinational RPN operator: {carry, result} = f(op, a, b), with b the former top of stack.
module stack_rpn_fn
  import stack_pkg::*;
#(
  parameter int DATA_W = STACK_DATA_W
) (
  input  rpn_op_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              carry,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum    = '0;
    carry  = 1'b0;
    result = a;
    case (op)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        carry  = sum[DATA_W];
        result = sum[DATA_W-1:0];
      end
      // The extra bit of the difference is the borrow.
      OP_SUB: begin
        sum    = {1'b0, a} - {1'b0, b};
        carry  = sum[DATA_W];
        result = sum[DATA_W-1:0];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = a;
    endcase
  end

endmodule

// File: rtl/stack_rpn_sequencer.sv
// Token-to-stack-command sequencer for RPN evaluation on an external LIFO.
// Optional STACK_RPN_FLAGS_EN adds O_CARRY / O_ZERO result flags.
module stack_rpn_sequencer
  import stack_pkg::*;
#(
  parameter int DATA_W = STACK_DATA_W,
  parameter int DEPTH  = STACK_DEPTH,
  parameter int IDX_W  = STACK_IDX_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_VALID,
  output logic              I_READY,
  input  logic [2:0]        I_OP,
  input  logic [DATA_W-1:0] I_DATA,
  output logic [DATA_W-1:0] O_RESULT,
  output logic              O_RES_VALID,
  output logic              O_ERR,
  output logic [IDX_W-1:0]  O_COUNT,
  output logic [1:0]        S_COMMAND,
  output logic [IDX_W-1:0]  S_INDEX,
  output logic [DATA_W-1:0] S_DATA,
  input  logic [DATA_W-1:0] S_O_DATA
`ifdef STACK_RPN_FLAGS_EN
  ,
  output logic              O_CARRY,
  output logic              O_ZERO
`endif
);

  localparam logic [2:0] ST_IDLE = RPN_IDLE;
  localparam logic [2:0] ST_POP1 = RPN_POP1;
  localparam logic [2:0] ST_POP2 = RPN_POP2;
  localparam logic [2:0] ST_EXEC = RPN_EXEC;
  localparam logic [2:0] ST_GET  = RPN_GET;
  localparam logic [2:0] ST_PUSH = RPN_PUSH;

  logic [2:0]        state_reg;
  rpn_op_e           op_reg;
  logic [IDX_W-1:0]  count_reg;
  logic [DATA_W-1:0] result_reg;
  logic [DATA_W-1:0] s_data_reg;
  logic [DATA_W-1:0] b_reg;
  logic              res_valid_reg;
  logic              err_reg;

  rpn_op_e           in_op;
  logic              fn_carry;
  logic [DATA_W-1:0] fn_result;
  logic              done_ok;
  logic [DATA_W-1:0] done_value;

  assign in_op = rpn_op_e'(I_OP);

  // Operand a is whatever the stack presents in EXEC; b was latched in POP2.
  stack_rpn_fn #(.DATA_W(DATA_W)) u_fn (
    .op     (op_reg),
    .a      (S_O_DATA),
    .b      (b_reg),
    .carry  (fn_carry),
    .result (fn_result)
  );

  always_comb begin
    S_COMMAND = NOP;
    case (state_reg)
      ST_POP1, ST_POP2: S_COMMAND = POP;
      ST_GET:           S_COMMAND = GET;
      ST_PUSH:          S_COMMAND = PUSH;
      default:          S_COMMAND = NOP;
    endcase
  end

  // A token completes on its PUSH edge, or in EXEC for DROP (popped value is the result).
  always_comb begin
    done_ok    = 1'b0;
    done_value = s_data_reg;
    if (state_reg == ST_PUSH) begin
      done_ok = 1'b1;
    end else if ((state_reg == ST_EXEC) && (op_reg == OP_DROP)) begin
      done_ok    = 1'b1;
      done_value = fn_result;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_reg     <= ST_IDLE;
      op_reg        <= OP_PUSHI;
      count_reg     <= '0;
      result_reg    <= '0;
      s_data_reg    <= '0;
      b_reg         <= '0;
      res_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      res_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
      if (done_ok) begin
        result_reg    <= done_value;
        res_valid_reg <= 1'b1;
      end
      case (state_reg)
        ST_IDLE: begin
          if (I_VALID) begin
            op_reg <= in_op;
            if (accept_error(in_op, int'(count_reg), DEPTH)) begin
              err_reg <= 1'b1;
            end else begin
              case (in_op)
                OP_PUSHI: begin
                  s_data_reg <= I_DATA;
                  state_reg  <= ST_PUSH;
                end
                OP_DUP:   state_reg <= ST_GET;
                default:  state_reg <= ST_POP1;
              endcase
            end
          end
        end
        ST_POP1: begin
          count_reg <= count_reg - IDX_W'(1);
          state_reg <= (op_reg == OP_DROP) ? ST_EXEC : ST_POP2;
        end
        ST_POP2: begin
          count_reg <= count_reg - IDX_W'(1);
          b_reg     <= S_O_DATA;
          state_reg <= ST_EXEC;
        end
        ST_EXEC: begin
          if (op_reg == OP_DROP) begin
            state_reg <= ST_IDLE;
          end else begin
            s_data_reg <= fn_result;
            state_reg  <= ST_PUSH;
          end
        end
        ST_GET:  state_reg <= ST_EXEC;
        ST_PUSH: begin
          count_reg <= count_reg + IDX_W'(1);
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign I_READY     = (state_reg == ST_IDLE);
  assign O_RESULT    = result_reg;
  assign O_RES_VALID = res_valid_reg;
  assign O_ERR       = err_reg;
  assign O_COUNT     = count_reg;
  assign S_INDEX     = '0;
  assign S_DATA      = s_data_reg;

`ifdef STACK_RPN_FLAGS_EN
  logic carry_pend_reg;
  logic carry_reg;
  logic zero_reg;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      carry_pend_reg <= 1'b0;
      carry_reg      <= 1'b0;
      zero_reg       <= 1'b0;
    end else begin
      if (state_reg == ST_IDLE) begin
        carry_pend_reg <= 1'b0;
      end else if (state_reg == ST_EXEC) begin
        carry_pend_reg <= fn_carry;
      end
      if (done_ok) begin
        carry_reg <= (state_reg == ST_PUSH) ? carry_pend_reg : 1'b0;
        zero_reg  <= (done_value == '0);
      end
    end
  end

  assign O_CARRY = carry_reg;
  assign O_ZERO  = zero_reg;
`else
  logic unused_carry;
  assign unused_carry = fn_carry;
`endif

endmodule
